if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline, sitting directly upstream of ID. It owns the PC and issues single-outstanding requests to the instruction memory. It registers the returned word plus its PC into the IF/ID pipeline register that feeds ID's `i_instr`/`i_pc`. It honours ID back-pressure (stall) and EX control-flow redirects, discarding in-flight fetches on redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, bubble word (`addi x0,x0,0`) driven on `o_InstrD` when invalid

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `o_ImemReq`  out  1  fetch request pulse; memory always accepts
- `o_ImemAddr`  out  32  fetch address, meaningful when `o_ImemReq`=1
- `i_ImemRdata`  in  32  returned instruction word
- `i_ImemValid`  in  1  response strobe, ≥1 cycle after request
- `i_StallD`  in  1  ID cannot accept; IF/ID must hold
- `i_Redirect`  in  1  EX branch/jump taken; kill younger fetches
- `i_RedirectPc`  in  32  redirect target
- `o_InstrD`  out  32  IF/ID instruction
- `o_PcD`  out  32  IF/ID PC
- `o_ValidD`  out  1  IF/ID holds a real instruction
- `o_PredTakenD`  out  1  IF/ID instruction was predicted taken (see Configuration)

## Operation
- Registers: `pc_q` (next issue address), `req_pc_q` (address of outstanding fetch), `buf_q` (held word), state, IF/ID triple.
- `free` = !`o_ValidD` | !`i_StallD`. `issue` = !`i_Redirect` & (IDLE | (WAIT & `i_ImemValid` & `free`) | (HOLD & !`i_StallD`)).
- On `issue`: `o_ImemReq`=1, `o_ImemAddr`=`pc_q`; next `req_pc_q`=`pc_q`, `pc_q`=`pc_q`+4 (mod 2^32, wraps 0xFFFF_FFFC→0).
- States:
  - IDLE: issue; →WAIT.
  - WAIT, no response: stay. Response & `free`: load IF/ID {`i_ImemRdata`, `req_pc_q`, 1}, issue next, stay WAIT. Response & !`free`: `buf_q`←rdata, →HOLD.
  - HOLD: no request outstanding. When !`i_StallD`: load IF/ID from `buf_q`/`req_pc_q`, issue, →WAIT.
  - DROP: outstanding response is stale; on `i_ImemValid` discard it, →IDLE.
- IF/ID not reloaded & !`i_StallD`: `o_ValidD`←0, `o_InstrD`←`NOP`.
- `i_Redirect`, highest priority, any state: `pc_q`←`i_RedirectPc`; `o_ValidD`←0, `o_InstrD`←`NOP`, `o_PredTakenD`←0 (overrides stall); `buf_q` discarded; no request that cycle.
  - WAIT without response →DROP. WAIT with response same cycle → response dropped, →IDLE.
  - HOLD →IDLE; IDLE →IDLE; DROP stays DROP, or →IDLE if `i_ImemValid` that cycle.
- `i_ImemValid` in IDLE/HOLD is a protocol error; ignored.

## Timing
- Reset values: state IDLE, `pc_q`=`RESET_PC`, `o_ValidD`=0, `o_InstrD`=`NOP`, `o_PcD`=0, `o_PredTakenD`=0; `o_ImemReq` combinational, 1 in the first cycle after reset release.
- Latency: request cycle N, response cycle N+L, `o_ValidD` high at N+L+1.
- Throughput: 1 instr/cycle with L=1 and no stall.
- Redirect at cycle N: first request to `i_RedirectPc` at N+1 (from WAIT-with-response or IDLE) or the cycle after the stale response returns (DROP).

## Configuration
- `IF_JAL_PREDICT_EN` defined: when a word is loaded into IF/ID (directly or from HOLD) with opcode 7'b1101111, the issue in that cycle uses `o_ImemAddr` = `req_pc_q` + J-immediate, and `pc_q` ← target+4. `o_PredTakenD`=1 for that instruction.
- Undefined: strictly sequential fetch; `o_PredTakenD` tied 0; no J-immediate logic.

## Structure
- Shared package `riscv_pkg`: `NOP` word, `OPC_JAL`, fetch state encoding (IDLE/WAIT/HOLD/DROP).
- One sub-module `imm_j_gen`: 32-bit instr → sign-extended J-immediate, instantiated only under `IF_JAL_PREDICT_EN`.

## Test plan
- Reset with `rst_n`=0 for 2 cycles → `o_ValidD`=0, `o_InstrD`=0x13. First post-reset cycle: `o_ImemReq`=1, `o_ImemAddr`=0x0.
- L=1 memory returning 0x7FF00293, 0x00530333 → `o_PcD` 0x0, 0x4 on consecutive cycles, `o_ImemAddr` 0x0,0x4,0x8 back-to-back.
- `i_StallD`=1 for 3 cycles while response 0x00530333 returns → IF/ID holds; state HOLD with no request. On release, next word is delivered in order with no loss or duplicate.
- L=3 memory, `i_Redirect`=1 with `i_RedirectPc`=0x100 one cycle after the request to 0x8 → the 0x8 response is dropped, next request is to 0x100, and `o_PcD`=0x100 is the next valid entry.
- Redirect concurrent with `i_StallD`=1 and a valid IF/ID → `o_ValidD`=0 next cycle.
- `IF_JAL_PREDICT_EN`: 0xFE5FF3EF (jal x7,-28) at PC 0x20 → next `o_ImemAddr`=0x4, `o_PredTakenD`=1. Without the macro → next address 0x24, flag 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: bubble word, opcodes and the fetch FSM encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [6:0]  OPC_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  function automatic logic is_jal(input logic [31:0] instr);
    return instr[6:0] == OPC_JAL;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
interface if_stage_if;

  logic        o_ImemReq;
  logic [31:0] o_ImemAddr;
  logic [31:0] i_ImemRdata;
  logic        i_ImemValid;

  modport master (
    output o_ImemReq,
    output o_ImemAddr,
    input  i_ImemRdata,
    input  i_ImemValid
  );

  modport slave (
    input  o_ImemReq,
    input  o_ImemAddr,
    output i_ImemRdata,
    output i_ImemValid
  );

endinterface

// File: rtl/imm_j_gen.sv
// J-type immediate extractor; only compiled when IF_JAL_PREDICT_EN is defined.
`ifdef IF_JAL_PREDICT_EN
module imm_j_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic unused_low;

  assign imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign unused_low = ^instr[11:0];

endmodule
`endif

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem requests and the IF/ID register.
// Define IF_JAL_PREDICT_EN to redirect fetch at JAL targets as soon as the JAL enters IF/ID.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        imem,
  input  logic              i_StallD,
  input  logic              i_Redirect,
  input  logic [31:0]       i_RedirectPc,
  output logic [31:0]       o_InstrD,
  output logic [31:0]       o_PcD,
  output logic              o_ValidD,
  output logic              o_PredTakenD
);

  fetch_state_t state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [31:0]  req_pc_q, req_pc_n;
  logic [31:0]  buf_q, buf_n;
  logic [31:0]  instr_q, pc_d_q;
  logic         valid_q, pred_q;

  logic         free;
  logic         issue;
  logic         load;
  logic [31:0]  load_word;
  logic [31:0]  issue_addr;
  logic         pred_hit;

  assign free = !valid_q || !i_StallD;

  always_comb begin
    state_n   = state_q;
    buf_n     = buf_q;
    issue     = 1'b0;
    load      = 1'b0;
    load_word = buf_q;
    if (i_Redirect) begin
      // A response landing in the redirect cycle is stale and simply not consumed.
      case (state_q)
        ST_WAIT: state_n = imem.i_ImemValid ? ST_IDLE : ST_DROP;
        ST_DROP: state_n = imem.i_ImemValid ? ST_IDLE : ST_DROP;
        default: state_n = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          issue   = 1'b1;
          state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.i_ImemValid) begin
            if (free) begin
              load      = 1'b1;
              load_word = imem.i_ImemRdata;
              issue     = 1'b1;
            end else begin
              buf_n   = imem.i_ImemRdata;
              state_n = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!i_StallD) begin
            load    = 1'b1;
            issue   = 1'b1;
            state_n = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem.i_ImemValid) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifdef IF_JAL_PREDICT_EN
  logic [31:0] imm_j;

  imm_j_gen u_imm_j_gen (
    .instr (load_word),
    .imm   (imm_j)
  );

  // The JAL being loaded is the word fetched from req_pc_q, so its target is known now.
  assign pred_hit   = load && is_jal(load_word);
  assign issue_addr = pred_hit ? (req_pc_q + imm_j) : pc_q;
`else
  assign pred_hit   = 1'b0;
  assign issue_addr = pc_q;
`endif

  always_comb begin
    pc_n     = pc_q;
    req_pc_n = req_pc_q;
    if (i_Redirect) begin
      pc_n = i_RedirectPc;
    end else if (issue) begin
      pc_n     = issue_addr + 32'd4;
      req_pc_n = issue_addr;
    end
  end

  assign imem.o_ImemReq  = issue && rst_n;
  assign imem.o_ImemAddr = issue_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      buf_q    <= NOP;
      valid_q  <= 1'b0;
      instr_q  <= NOP;
      pc_d_q   <= 32'd0;
      pred_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      req_pc_q <= req_pc_n;
      buf_q    <= buf_n;
      // Redirect flushes IF/ID even while ID is stalled.
      if (i_Redirect) begin
        valid_q <= 1'b0;
        instr_q <= NOP;
        pred_q  <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        instr_q <= load_word;
        pc_d_q  <= req_pc_q;
        pred_q  <= pred_hit;
      end else if (!i_StallD) begin
        valid_q <= 1'b0;
        instr_q <= NOP;
        pred_q  <= 1'b0;
      end
    end
  end

  assign o_InstrD     = instr_q;
  assign o_PcD        = pc_d_q;
  assign o_ValidD     = valid_q;
  assign o_PredTakenD = pred_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected fetch addresses and IF/ID entries are queued per
// scenario and popped as the DUT issues requests and ID accepts instructions.
module tb_if_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        pred_d;

  if_stage_if imem ();

  if_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem.master),
    .i_StallD     (stall),
    .i_Redirect   (redirect),
    .i_RedirectPc (redirect_pc),
    .o_InstrD     (instr_d),
    .o_PcD        (pc_d),
    .o_ValidD     (valid_d),
    .o_PredTakenD (pred_d)
  );

  int     vectors;
  int     miscompares;
  int     cyc;
  int     lat;
  logic [31:0] exp_addr[$];
  entry_t      exp_d[$];
  pend_t       pend[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h7FF0_0293;
      32'h0000_0004: return 32'h0053_0333;
      32'h0000_0020: return 32'hFE5F_F3EF;
      default:       return {a[19:0], 12'h013};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_entry(input logic [31:0] pc, input logic pred);
    exp_d.push_back('{pc: pc, instr: word(pc), pred: pred});
  endtask

  // Drive one cycle's inputs, then sample the DUT on the falling edge.
  task automatic apply(input logic s, input logic r, input logic [31:0] rpc);
    entry_t e;
    logic [31:0] a;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      imem.i_ImemValid = 1'b1;
      imem.i_ImemRdata = word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem.i_ImemValid = 1'b0;
      imem.i_ImemRdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    if (imem.o_ImemReq) begin
      if (exp_addr.size() == 0) begin
        check("req_extra", {31'b0, imem.o_ImemReq}, 32'd0);
      end else begin
        a = exp_addr.pop_front();
        check("req_addr", imem.o_ImemAddr, a);
      end
      pend.push_back('{addr: imem.o_ImemAddr, due: cyc + lat});
    end
    if (valid_d && !stall) begin
      $display("xact cyc=%0d pc=%08h instr=%08h pred=%0d", cyc, pc_d, instr_d, pred_d);
      if (exp_d.size() == 0) begin
        check("entry_extra", {31'b0, valid_d}, 32'd0);
      end else begin
        e = exp_d.pop_front();
        check("entry_pc", pc_d, e.pc);
        check("entry_instr", instr_d, e.instr);
        check("entry_pred", {31'b0, pred_d}, {31'b0, e.pred});
      end
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    apply(s, r, rpc);
  endtask

  task automatic do_reset(input int l);
    check("addr_left", 32'(exp_addr.size()), 32'd0);
    check("entry_left", 32'(exp_d.size()), 32'd0);
    exp_addr.delete();
    exp_d.delete();
    pend.delete();
    rst_n            = 1'b0;
    stall            = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = 32'd0;
    imem.i_ImemValid = 1'b0;
    imem.i_ImemRdata = 32'd0;
    lat              = l;
    cyc              = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Back-to-back fetch with single-cycle memory; reset values checked in cycle 0.
    do_reset(1);
    for (int i = 0; i < 6; i++) exp_addr.push_back(32'(4 * i));
    for (int i = 0; i < 4; i++) push_entry(32'(4 * i), 1'b0);
    apply(1'b0, 1'b0, 32'd0);
    check("rst_valid", {31'b0, valid_d}, 32'd0);
    check("rst_instr", instr_d, 32'h0000_0013);
    check("rst_pc", pc_d, 32'd0);
    check("rst_pred", {31'b0, pred_d}, 32'd0);
    check("rst_req", {31'b0, imem.o_ImemReq}, 32'd1);
    repeat (5) step(1'b0, 1'b0, 32'd0);

    // ID stalls for 3 cycles while the second word returns.
    do_reset(1);
    foreach (exp_addr[i]) ;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);
    exp_addr.push_back(32'h10);
    push_entry(32'h0, 1'b0);
    push_entry(32'h4, 1'b0);
    push_entry(32'h8, 1'b0);
    apply(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("hold_req", {31'b0, imem.o_ImemReq}, 32'd0);
    check("hold_valid", {31'b0, valid_d}, 32'd1);
    check("hold_pc", pc_d, 32'h0);
    step(1'b1, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 32'd0);

    // Latency-3 memory, redirect to 0x100 one cycle after the request to 0x8.
    do_reset(3);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'h100);
    exp_addr.push_back(32'h104);
    push_entry(32'h0, 1'b0);
    push_entry(32'h4, 1'b0);
    push_entry(32'h100, 1'b0);
    apply(1'b0, 1'b0, 32'd0);
    repeat (6) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 32'd0);
    check("drop_valid", {31'b0, valid_d}, 32'd0);
    check("drop_instr", instr_d, 32'h0000_0013);
    repeat (6) step(1'b0, 1'b0, 32'd0);

    // Redirect while ID stalls on a valid IF/ID entry.
    do_reset(1);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h40);
    exp_addr.push_back(32'h44);
    exp_addr.push_back(32'h48);
    push_entry(32'h40, 1'b0);
    apply(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'd0);
    check("redir_stall_valid", {31'b0, valid_d}, 32'd0);
    repeat (2) step(1'b0, 1'b0, 32'd0);

    // JAL x7,-28 at 0x20.
    do_reset(1);
`ifdef IF_JAL_PREDICT_EN
    exp_addr.push_back(32'h20);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);
    push_entry(32'h20, 1'b1);
    push_entry(32'h4, 1'b0);
`else
    exp_addr.push_back(32'h20);
    exp_addr.push_back(32'h24);
    exp_addr.push_back(32'h28);
    exp_addr.push_back(32'h2C);
    push_entry(32'h20, 1'b0);
    push_entry(32'h24, 1'b0);
`endif
    apply(1'b0, 1'b1, 32'h20);
    check("redir_idle_req", {31'b0, imem.o_ImemReq}, 32'd0);
    repeat (4) step(1'b0, 1'b0, 32'd0);

    // PC wraps from 0xFFFF_FFFC to 0.
    do_reset(1);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    push_entry(32'hFFFF_FFFC, 1'b0);
    push_entry(32'h0, 1'b0);
    apply(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b0, 32'd0);

    check("addr_left", 32'(exp_addr.size()), 32'd0);
    check("entry_left", 32'(exp_d.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
